regfile_mp: RTL

- Parametrised multi-port integer register file with per-register busy scoreboard. Successor to the single-write, dual-read file.
- Sits in the decode/writeback boundary of the pipelined core:
  - decode reads operands and allocates destinations;
  - writeback ports retire results and clear busy bits.
- Register 0 is hardwired zero.
- Optional same-cycle write-to-read bypass.

---
 rtl/regfile_mp.sv | 91 +++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// Multi-port register file with per-register busy scoreboard; x0 is hardwired zero.
// Optional same-cycle write-to-read bypass enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned NR    = 2,
    parameter int unsigned NW    = 2,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NW-1:0]       we,
    input  logic [NW*AW-1:0]    waddr,
    input  logic [NW*WIDTH-1:0] wdata,
    input  logic [NR*AW-1:0]    raddr,
    output logic [NR*WIDTH-1:0] rdata,
    output logic [NR-1:0]       rbusy,
    input  logic                alloc,
    input  logic [AW-1:0]       alloc_dest,
    input  logic                flush,
    output logic [DEPTH-1:0]    busy_vec
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] busy_nxt;

    // Data storage; ports are visited in ascending order so the highest index wins a conflict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < DEPTH; r++) begin
                mem[r] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < NW; k++) begin
                if (we[k] && (waddr[k*AW +: AW] != '0)) begin
                    mem[waddr[k*AW +: AW]] <= wdata[k*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Busy next state: flush beats alloc, alloc beats writeback clear.
    always_comb begin
        busy_nxt = busy_vec;
        for (int unsigned k = 0; k < NW; k++) begin
            if (we[k]) begin
                busy_nxt[waddr[k*AW +: AW]] = 1'b0;
            end
        end
        if (alloc) begin
            busy_nxt[alloc_dest] = 1'b1;
        end
        if (flush) begin
            busy_nxt = '0;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_vec <= '0;
        end else begin
            busy_vec <= busy_nxt;
        end
    end

    // Combinational read ports.
    always_comb begin
        logic [AW-1:0] ra;
        rdata = '0;
        rbusy = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            ra = raddr[i*AW +: AW];
            rdata[i*WIDTH +: WIDTH] = mem[ra];
            rbusy[i] = busy_vec[ra];
`ifdef REGFILE_BYPASS_EN
            for (int unsigned k = 0; k < NW; k++) begin
                if (we[k] && (waddr[k*AW +: AW] == ra)) begin
                    rdata[i*WIDTH +: WIDTH] = wdata[k*WIDTH +: WIDTH];
                    rbusy[i] = alloc && (alloc_dest == ra);
                end
            end
`endif
            if (ra == '0) begin
                rdata[i*WIDTH +: WIDTH] = '0;
                rbusy[i] = 1'b0;
            end
        end
    end

endmodule
